// File: rtl/lane_spawner_if.sv
// lane_spawner_if: control inputs and lane outputs exchanged between the game core and lane_spawner
interface lane_spawner_if #(
  parameter int WIDTH = 16,
  parameter int COLS  = 16
);
  logic             enable;
  logic             clear;
  logic [3:0]       density;
  logic [WIDTH-1:0] rnd;
  logic [COLS-1:0]  lane;
  logic             step;
  logic             spawn;
  modport master (output enable, clear, density, rnd, input lane, step, spawn);
  modport slave  (input enable, clear, density, rnd, output lane, step, spawn);
endinterface

// File: rtl/lane_spawner.sv
// lane_spawner: divides clk to a lane step rate and scrolls a lane of cars whose gaps/lengths come from a random word
module lane_spawner #(
  parameter int WIDTH    = 16,
  parameter int COLS     = 16,
  parameter int TICK_DIV = 25_000_000,
  parameter int MIN_GAP  = 2,
  parameter int MAX_LEN  = 3,
  parameter int DIR      = 0
) (
  input logic          clk,
  input logic          reset,
  lane_spawner_if.slave bus
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int GW = $clog2(MIN_GAP + 1);
  typedef enum logic {GAP, CAR} state_t;
  state_t          state, state_n;
  logic [TW-1:0]   tick_cnt;
  logic [GW-1:0]   gap_cnt, gap_n;
  logic [2:0]      car_cnt, car_cnt_n, car_len, car_len_n, len_r;
  logic [COLS-1:0] lane_q, lane_n;
  logic            step_q, spawn_q, spn, inj, last, step_edge;
  assign last      = tick_cnt == TW'(TICK_DIV - 1);
  assign step_edge = bus.enable && last;
  assign len_r     = {1'b0, bus.rnd[5:4]} + 3'd1;
  assign lane_n    = (DIR != 0) ? {lane_q[COLS-2:0], inj} : {inj, lane_q[COLS-1:1]};
  assign bus.lane  = lane_q;
  assign bus.step  = step_q;
  assign bus.spawn = spawn_q;
  always_comb begin
    state_n   = state;
    gap_n     = gap_cnt;
    car_cnt_n = car_cnt;
    car_len_n = car_len;
    inj       = 1'b0;
    spn       = 1'b0;
    if (state == GAP) begin
      if (gap_cnt < GW'(MIN_GAP)) gap_n = gap_cnt + GW'(1);
      else if (bus.rnd[3:0] < bus.density) begin
        inj       = 1'b1;
        spn       = 1'b1;
        state_n   = CAR;
        car_cnt_n = 3'd1;
        car_len_n = (len_r > 3'(MAX_LEN)) ? 3'(MAX_LEN) : len_r;
      end
    end else if (car_cnt < car_len) begin
      inj       = 1'b1;
      car_cnt_n = car_cnt + 3'd1;
    end else begin
      state_n = GAP;
      gap_n   = GW'(1);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q   <= '0;
      step_q   <= 1'b0;
      spawn_q  <= 1'b0;
      tick_cnt <= '0;
      state    <= GAP;
      gap_cnt  <= '0;
      car_cnt  <= 3'd0;
      car_len  <= 3'd1;
    end else if (bus.clear) begin
      lane_q   <= '0;
      step_q   <= 1'b0;
      spawn_q  <= 1'b0;
      tick_cnt <= '0;
      state    <= GAP;
      gap_cnt  <= '0;
    end else begin
      step_q  <= step_edge;
      spawn_q <= step_edge && spn;
      if (bus.enable) tick_cnt <= last ? '0 : tick_cnt + TW'(1);
      if (step_edge) begin
        lane_q  <= lane_n;
        state   <= state_n;
        gap_cnt <= gap_n;
        car_cnt <= car_cnt_n;
        car_len <= car_len_n;
      end
    end
  end
endmodule

// File: doc/lane_spawner.md
# lane_spawner

Consumes the free-running pseudo-random word from the game's 16-bit LFSR and turns it into a scrolling lane of cars for the Frogger playfield. The block divides the system clock down to a lane step rate. On each step it shifts a COLS-bit lane register by one column and injects a new column bit. That bit is decided by a gap/car state machine driven by the random word and a density threshold. The lane output feeds the LED-matrix row driver and the collision checker.

## Interface
- WIDTH, 16, width of the random input word; must be ≥ 6
- COLS, 16, lane length in columns
- TICK_DIV, 25_000_000, clocks per lane step; must be ≥ 2
- MIN_GAP, 2, minimum empty columns between cars; must be ≥ 1
- MAX_LEN, 3, maximum car length in columns, 1..4
- DIR, 0, 0: inject at lane[COLS-1] and shift toward bit 0; 1: inject at lane[0] and shift toward bit COLS-1
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  game running; low freezes all state
- clear  in  1  synchronous lane flush; priority over stepping
- density  in  4  spawn threshold; 0 means never spawn
- rnd  in  WIDTH  random word from the LFSR, sampled only on step edges
- lane  out  COLS  current lane occupancy, 1 = car
- step  out  1  one-cycle pulse while a newly shifted lane is visible
- spawn  out  1  one-cycle pulse, coincident with step, when the injected bit starts a new car

## Operation
- Reset (reset low) acts immediately, independent of clk:
  - lane=0, step=0, spawn=0
  - tick_cnt=0, state=GAP, gap_cnt=0, car_cnt=0, car_len=1
- Tick counter:
  - with enable=1, tick_cnt counts 0..TICK_DIV-1 and wraps
  - the edge at tick_cnt==TICK_DIV-1 is a step edge
  - with enable=0, tick_cnt holds
- On a step edge, the FSM chooses the injected bit e:
  - GAP, gap_cnt < MIN_GAP: e=0, gap_cnt++
  - GAP, gap_cnt ≥ MIN_GAP, rnd[3:0] < density: e=1, go to CAR, car_cnt=1, car_len=min(rnd[5:4]+1, MAX_LEN), spawn=1
  - GAP, gap_cnt ≥ MIN_GAP, otherwise: e=0, gap_cnt holds (saturates)
  - CAR, car_cnt < car_len: e=1, car_cnt++
  - CAR, car_cnt == car_len: e=0, go to GAP, gap_cnt=1
- Shift on every step edge:
  - DIR=0: lane <= {e, lane[COLS-1:1]}
  - DIR=1: lane <= {lane[COLS-2:0], e}
  - bits shifted off the far end are discarded
- Width rules:
  - the rnd[3:0] < density compare is unsigned 4-bit
  - car_len is 3 bits
  - gap_cnt saturates at MIN_GAP, so it never wraps
- clear=1 on an edge:
  - lane=0, tick_cnt=0, state=GAP, gap_cnt=0
  - step and spawn are 0 the next cycle
  - applies regardless of enable and overrides a coincident step edge
- rnd is only sampled on step edges. Its value at any other time has no effect, so rnd may sit at any value, including the LFSR's post-reset 0x0000.

## Timing
- step and spawn are registered. They go high in the cycle right after the step edge, the same cycle the new lane value appears, and last exactly one cycle.
- Step spacing is exactly TICK_DIV clocks while enable stays high.
- Deasserting enable pauses the period. On resume, the period finishes with the remaining count; it does not restart.
- Releasing reset: the first step edge is the TICK_DIV-th clk edge with enable=1.
- Reset asserted mid-operation forces every output to its reset value within the same cycle, with no clock edge needed.
- Car-to-car spacing is at least MIN_GAP zero columns; a car is 1..MAX_LEN one columns.

## Test plan
Common settings: COLS=8, TICK_DIV=4, MIN_GAP=2, MAX_LEN=3, DIR=0, enable=1.

- Reset and density=0 over 40 clocks -> step pulses every 4 clocks (10 total); lane stays 0x00; spawn never asserts.
- rnd=0x0000, density=15, 6 steps -> injected sequence 0,0,1,0,0,1; lane=0x90; spawn on steps 3 and 6 only.
- rnd=0x0030, density=1, 8 steps -> car length 3; injected sequence 0,0,1,1,1,0,0,1; lane=0x9C; spawn on steps 3 and 8.
- enable low for 10 clocks after 2 counts into a period -> no step, lane unchanged; step arrives 2 clocks after enable returns high.
- clear asserted on a step edge with lane=0x9C -> lane=0x00, step=0 and spawn=0 next cycle; the next 2 injected bits are 0.
- reset pulled low mid-period with lane=0x90 -> lane=0x00, step=0, spawn=0 before the next clk edge; counting restarts from 0 after release.
